frame_reader: RTL

FRAME_READER -- requirements
Module: frame_reader

---
 rtl/gpu_pkg.sv | 14 +
 rtl/frame_reader_fifo.sv | 51 +++++
 rtl/frame_reader.sv | 121 ++++++++++++
 3 files changed

// File: rtl/gpu_pkg.sv
// Shared types and constants for the GPU display path.
package gpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } frame_reader_state_t;

  localparam int unsigned FRAME_WORDS_640X480 = 307200;
  localparam int          CNT_W               = 19;

endpackage

// File: rtl/frame_reader_fifo.sv
// Show-ahead pixel FIFO: the head entry is always presented on dout,
// so a consumer holding ready high drains one entry per cycle.
module frame_reader_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  // A pop frees the head slot in the same cycle, so a full FIFO may still accept.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/frame_reader.sv
// Streams one frame of 32-bit words from SDRAM (Avalon-MM reads) into RGB pixels.
// Define FRAME_READER_LOOP_EN for continuous refresh (DONE restarts the fetch).
module frame_reader
  import gpu_pkg::*;
#(
  parameter logic [25:0] BASE_ADDR   = 26'h0,
  parameter int unsigned FRAME_WORDS = FRAME_WORDS_640X480,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        SD_read,
  output logic [25:0] SD_address,
  input  logic        waitrequest,
  input  logic [31:0] SD_rdata,
  input  logic        SD_rdatavalid,
  output logic [7:0]  pix_r,
  output logic [7:0]  pix_g,
  output logic [7:0]  pix_b,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        busy,
  output logic        frame_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(FRAME_WORDS);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

`ifdef FRAME_READER_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  frame_reader_state_t state, state_next;

  logic [CNT_W-1:0] issued, outstanding;
  logic [AW:0]      fifo_count;
  logic             fifo_empty;
  logic [23:0]      fifo_dout;
  logic             accept, ret, pop, room, load, last_pop;
  logic             rdata_unused;

  assign rdata_unused = ^SD_rdata[31:24];

  assign accept   = SD_read && !waitrequest;
  // Returns are only meaningful for the frame in progress; stale ones after a reset are dropped.
  assign ret      = SD_rdatavalid && (state == FETCH || state == DRAIN);
  assign pop      = pix_valid && pix_ready;
  assign room     = (CNT_W'(fifo_count) + outstanding) < DEPTH_C;
  assign load     = (state == IDLE && start) || (state == DONE && LOOP);
  assign last_pop = (fifo_count == (AW+1)'(1)) && pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = FETCH;
      FETCH:   if (issued == LAST) state_next = DRAIN;
      DRAIN:   if (outstanding == '0 && (fifo_empty || last_pop)) state_next = DONE;
      DONE:    state_next = LOOP ? FETCH : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Requests are gated so every word in flight already has a FIFO slot reserved.
  always_comb begin
    busy       = (state != IDLE);
    frame_done = (state == DONE);
    SD_read    = (state == FETCH) && (issued < LAST) && room;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      SD_address  <= BASE_ADDR;
      issued      <= '0;
      outstanding <= '0;
    end else if (load) begin
      SD_address  <= BASE_ADDR;
      issued      <= '0;
      outstanding <= '0;
    end else begin
      if (accept) begin
        SD_address <= SD_address + 26'd4;
        issued     <= issued + ONE;
      end
      case ({accept, ret})
        2'b10:   outstanding <= outstanding + ONE;
        2'b01:   outstanding <= outstanding - ONE;
        default: outstanding <= outstanding;
      endcase
    end
  end

  frame_reader_fifo #(
    .WIDTH(24),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (ret),
    .din   (SD_rdata[23:0]),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign pix_valid = !fifo_empty;
  assign pix_r     = fifo_dout[7:0];
  assign pix_g     = fifo_dout[15:8];
  assign pix_b     = fifo_dout[23:16];

endmodule
